// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1 -- N-to-1 multiplexer with request arbitration and a registered
// output stage (one beat of buffering, valid/ready on both sides).
//
// Build option:
//   ARB_MUX_RR_EN  defined   -> arbitrate mode uses round-robin starting at rr_ptr
//   ARB_MUX_RR_EN  undefined -> arbitrate mode uses fixed priority (lowest index wins)
//
// Parameters:
//   WIDTH   data width per channel
//   NUM_CH  channel count (2..16); SEL_W = clog2(NUM_CH) is derived, not overridable
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (combinational, at most one bit high)
//   sel_mode   0 = arbitrate, 1 = direct select of channel ctr
//   ctr        channel index used in direct mode
//   out_data   registered data of the selected channel
//   out_ch     registered source channel index of out_data
//   out_valid  out_data/out_ch hold a beat
//   out_ready  downstream accept

module arb_mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    sel_mode,
    input  logic [SEL_W-1:0]        ctr,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             load_en;
    logic             fire;

    logic             direct_valid;
    logic [SEL_W-1:0] direct_idx;
    logic             arb_valid;
    logic [SEL_W-1:0] arb_idx;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;

    // The output register can take a new beat when it is empty or being drained.
    assign load_en = !out_valid || out_ready;
    assign fire    = load_en && grant_valid;

    // Direct mode: compare ctr against each legal index instead of indexing
    // in_valid with ctr, so an out-of-range ctr simply matches nothing.
    always_comb begin
        direct_valid = 1'b0;
        direct_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ctr) == i && in_valid[i]) begin
                direct_valid = 1'b1;
                direct_idx   = SEL_W'(i);
            end
        end
    end

`ifdef ARB_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_ptr_next;

    // Round-robin: walk upward from rr_ptr with wrap, first valid request wins.
    always_comb begin
        int idx;
        arb_valid = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!arb_valid && in_valid[idx]) begin
                arb_valid = 1'b1;
                arb_idx   = SEL_W'(idx);
            end
        end
    end

    // Pointer moves one past the granted channel, wrapping at NUM_CH-1.
    always_comb begin
        if (grant_idx == SEL_W'(NUM_CH - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // Only arbitrated handshakes advance the pointer; direct transfers leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (fire && !sel_mode) begin
            rr_ptr <= rr_ptr_next;
        end
    end
`else
    // Fixed priority: scan from the top down so the lowest valid index is the
    // last assignment and therefore wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                arb_valid = 1'b1;
                arb_idx   = SEL_W'(i);
            end
        end
    end
`endif

    always_comb begin
        if (sel_mode) begin
            grant_valid = direct_valid;
            grant_idx   = direct_idx;
        end else begin
            grant_valid = arb_valid;
            grant_idx   = arb_idx;
        end
    end

    always_comb begin
        sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // rst_n is folded in so no channel sees an accept while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && fire) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // With no grant while the register could load, the beat is retired but
    // data and channel are left as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb_arb_mux_nto1 -- directed scoreboard bench for arb_mux_nto1.
// Main instance WIDTH=32, NUM_CH=4; a second instance with NUM_CH=5 exercises
// an out-of-range direct-mode index. Expectations track ARB_MUX_RR_EN.

module tb_arb_mux_nto1;

`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] chd [4];
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        sel_mode;
    logic [1:0]  ctr;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [2:0]  ctr5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_valid5;

    exp_t        sb [$];
    int          total;
    int          bad;

    assign in_data  = {chd[3], chd[2], chd[1], chd[0]};
    assign in_data5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    arb_mux_nto1 #(.WIDTH(32), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_mode  (sel_mode),
        .ctr       (ctr),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    arb_mux_nto1 #(.WIDTH(8), .NUM_CH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .sel_mode  (1'b1),
        .ctr       (ctr5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
        .out_ready (1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input logic v, input logic [1:0] c, input logic [31:0] d,
                               input string name);
        checkEq({name, " out_valid"}, 64'(out_valid), 64'(v));
        checkEq({name, " out_ch"},    64'(out_ch),    64'(c));
        checkEq({name, " out_data"},  64'(out_data),  64'(d));
    endtask

    // Drive one vector, check the combinational accept, and queue the beat
    // the hand-computed accept says will be captured at the next edge.
    task automatic applyStimulus(input logic [3:0] v, input logic m, input logic [1:0] c,
                                 input logic r, input logic [3:0] exp_rdy, input string name);
        exp_t e;
        in_valid  = v;
        sel_mode  = m;
        ctr       = c;
        out_ready = r;
        #1;
        checkEq({name, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.ch   = 2'(i);
                e.data = chd[i];
                sb.push_back(e);
            end
        end
    endtask

    task automatic step(input logic [3:0] v, input logic m, input logic [1:0] c,
                        input logic r, input logic [3:0] exp_rdy, input string name);
        @(posedge clk);
        #1;
        applyStimulus(v, m, c, r, exp_rdy, name);
    endtask

    // Monitor: a beat is consumed when out_valid and out_ready are both high
    // between edges; compare it against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected beat: got ch=%0d data=%0h expected none",
                         out_ch, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkEq("sb out_ch", 64'(out_ch), 64'(e.ch));
                checkEq("sb out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        chd[0]    = 32'hC0DE_0000;
        chd[1]    = 32'h0000_0011;
        chd[2]    = 32'h0000_0022;
        chd[3]    = 32'h0000_0033;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        sel_mode  = 1'b1;
        ctr       = 2'd2;
        out_ready = 1'b1;
        in_valid5 = 5'b11111;
        ctr5      = 3'd7;

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] reset state");
        checkOutput(1'b0, 2'd0, 32'h0, "reset");
        checkEq("reset in_ready", 64'(in_ready), 64'(4'b0000));

        // Release between edges; the very next edge must already grant.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, "direct ctr2");
        step(4'b1101, 1'b1, 2'd1, 1'b1, 4'b0000, "direct ctr1 idle");
        checkOutput(1'b1, 2'd2, 32'h22, "direct ctr2 beat");
        step(4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, "idle");
        checkOutput(1'b0, 2'd2, 32'h22, "no grant hold");

        $display("[TB] arbitration, all requesting");
        step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, "arb1111 a");
        step(4'b1111, 1'b0, 2'd0, 1'b1, RR ? 4'b0010 : 4'b0001, "arb1111 b");
        step(4'b1111, 1'b0, 2'd0, 1'b1, RR ? 4'b0100 : 4'b0001, "arb1111 c");
        step(4'b1111, 1'b0, 2'd0, 1'b1, RR ? 4'b1000 : 4'b0001, "arb1111 d");
        step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, "arb1111 e");

        $display("[TB] arbitration, sparse requests");
        step(4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, "arb1010 a");
        step(4'b1010, 1'b0, 2'd0, 1'b1, RR ? 4'b1000 : 4'b0010, "arb1010 b");
        step(4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, "arb1010 c");
        step(4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, "arb0100");
        step(4'b0011, 1'b0, 2'd0, 1'b1, 4'b0001, "arb0011 a");
        step(4'b0011, 1'b0, 2'd0, 1'b1, RR ? 4'b0010 : 4'b0001, "arb0011 b");
        step(4'b0011, 1'b0, 2'd0, 1'b1, 4'b0001, "arb0011 c");
        step(4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, "direct no ptr move");
        step(4'b1100, 1'b0, 2'd0, 1'b1, 4'b0100, "arb1100");

        $display("[TB] backpressure");
        step(4'b0110, 1'b0, 2'd0, 1'b1, 4'b0010, "bp load");
        step(4'b0110, 1'b0, 2'd0, 1'b0, 4'b0000, "bp hold1");
        checkOutput(1'b1, 2'd1, 32'h11, "bp hold1");
        step(4'b0110, 1'b0, 2'd0, 1'b0, 4'b0000, "bp hold2");
        checkOutput(1'b1, 2'd1, 32'h11, "bp hold2");
        step(4'b0110, 1'b0, 2'd0, 1'b0, 4'b0000, "bp hold3");
        checkOutput(1'b1, 2'd1, 32'h11, "bp hold3");
        step(4'b0110, 1'b0, 2'd0, 1'b1, RR ? 4'b0100 : 4'b0010, "bp release");
        checkOutput(1'b1, 2'd1, 32'h11, "bp release");
        step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, "drain1");
        checkOutput(1'b1, RR ? 2'd2 : 2'd1, RR ? 32'h22 : 32'h11, "drain1");
        step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, "drain2");
        checkOutput(1'b0, RR ? 2'd2 : 2'd1, RR ? 32'h22 : 32'h11, "drain2");

        $display("[TB] reset mid-transfer");
        chd[2] = 32'hDEADBEEF;
        step(4'b0100, 1'b1, 2'd2, 1'b0, 4'b0100, "pre-reset load");
        step(4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000, "pre-reset hold");
        checkOutput(1'b1, 2'd2, 32'hDEADBEEF, "pre-reset");
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput(1'b0, 2'd0, 32'h0, "async reset");
        checkEq("async reset in_ready", 64'(in_ready), 64'(4'b0000));
        sb.delete();
        in_valid = 4'b0000;
        chd[2]   = 32'h0000_0022;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(4'b1100, 1'b0, 2'd0, 1'b1, 4'b0100, "post-reset ptr");
        step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, "post-reset idle");
        checkOutput(1'b1, 2'd2, 32'h22, "post-reset beat");

        $display("[TB] NUM_CH=5 direct index range");
        @(posedge clk);
        #1;
        ctr5 = 3'd4;
        #1;
        checkEq("ch5 ctr4 in_ready", 64'(in_ready5), 64'(5'b10000));
        @(posedge clk);
        #1;
        checkEq("ch5 ctr4 out_valid", 64'(out_valid5), 64'(1'b1));
        checkEq("ch5 ctr4 out_ch", 64'(out_ch5), 64'(3'd4));
        checkEq("ch5 ctr4 out_data", 64'(out_data5), 64'(8'h44));
        ctr5 = 3'd7;
        #1;
        checkEq("ch5 ctr7 in_ready", 64'(in_ready5), 64'(5'b00000));
        @(posedge clk);
        #1;
        checkEq("ch5 ctr7 out_valid", 64'(out_valid5), 64'(1'b0));

        repeat (3) @(posedge clk);
        #1;
        checkEq("scoreboard empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_nto1.md
ARB_MUX_NTO1 -- requirements
Module: arb_mux_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 SHALL have parameter NUM_CH, default 4: channel count, range 2..16; SEL_W = clog2(NUM_CH), derived internally and not overridable.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid, input, NUM_CH: per-channel request.
REQ-007 SHALL have port in_ready, output, NUM_CH: per-channel accept, combinational.
REQ-008 SHALL have port sel_mode, input, 1: 0 = arbitrate, 1 = direct select via ctr.
REQ-009 SHALL have port ctr, input, SEL_W: channel index used in direct mode.
REQ-010 SHALL have port out_data, output, WIDTH: registered selected data.
REQ-011 SHALL have port out_ch, output, SEL_W: registered source index of out_data.
REQ-012 SHALL have port out_valid, output, 1: out_data/out_ch hold a valid beat.
REQ-013 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-014 SHALL define load_en = !out_valid || out_ready; the output register loads only when load_en=1 and a grant exists.
REQ-015 Direct mode: SHALL grant channel ctr iff ctr < NUM_CH and in_valid[ctr]=1; ctr >= NUM_CH SHALL produce no grant and no error.
REQ-016 Arbitrate mode, RR compiled in: SHALL grant the first valid channel searching upward from pointer rr_ptr and wrapping from NUM_CH-1 to 0.
REQ-017 rr_ptr SHALL update to (g+1) mod NUM_CH only on a completed arbitrate-mode handshake with channel g; direct-mode transfers SHALL NOT move rr_ptr.
REQ-018 in_ready[i] SHALL be 1 iff load_en=1, a grant exists, and the grant is i; at most one in_ready bit SHALL be high per cycle.
REQ-019 On handshake with channel g: next cycle out_data = channel g data, out_ch = g, out_valid = 1; latency 1 cycle; throughput 1 beat/cycle with out_ready held high.
REQ-020 If no grant while load_en=1: out_valid SHALL go 0 next cycle; out_data and out_ch SHALL hold their previous values.
REQ-021 While out_valid=1 and out_ready=0: out_data, out_ch and out_valid SHALL be held stable and all in_ready SHALL be 0.
REQ-022 Changes to sel_mode or ctr SHALL affect only the next grant decision, never a beat already in the output register.
REQ-023 The arbiter SHALL NOT require in_valid to be held; a deasserted request is simply not granted.

Reset
REQ-024 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
REQ-025 in_ready SHALL be 0 while rst_n=0; a reset mid-transfer SHALL drop the registered beat without delivering it.
REQ-026 The first grant after reset release SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ARB_MUX_RR_EN defined: arbitrate mode SHALL use round-robin per REQ-016/017.
REQ-028 Macro ARB_MUX_RR_EN undefined: arbitrate mode SHALL use fixed priority, lowest valid index wins; rr_ptr SHALL be absent; direct mode SHALL be unchanged.

Verification (WIDTH=32, NUM_CH=4)
REQ-029 Reset with out_valid=1 and out_data=0xDEADBEEF, pull rst_n low mid-cycle -> out_valid=0, out_data=0, out_ch=0 immediately, before any clock edge.
REQ-030 Direct mode, ctr=2, in_valid=4'b1111, ch2=0x00000022, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x22, out_ch=2; repeat with ctr=5 is illegal for NUM_CH=4, so use NUM_CH=5, ctr=7 -> no in_ready and out_valid=0.
REQ-031 RR build, arbitrate mode, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 RR build, rr_ptr=3, in_valid=4'b0011 -> grant ch0, then ch1, then ch0 (wrap-around).
REQ-033 Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0110 -> in_ready=0 and out_data stable for all 3 cycles; on out_ready=1, the same-cycle handshake grants the next channel.
REQ-034 Build without ARB_MUX_RR_EN, in_valid=4'b1010 held, out_ready=1 -> out_ch=1 every cycle and ch3 is never granted.
